// File: rtl/ts_pkg.sv
// Shared constants for the timestamp capture block: default widths/depths and the
// helper that sizes the occupancy counter.
package ts_pkg;

    localparam int unsigned CwDefault         = 32;
    localparam int unsigned DepthDefault      = 8;
    localparam int unsigned LevelWidthDefault = $clog2(DepthDefault) + 1;

    // Occupancy needs one extra bit so that a full FIFO (level == depth) is representable.
    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ts_fifo.sv
// Synchronous FIFO with explicit occupancy tracking and a combinational head read,
// so a written entry is visible the cycle after the write edge.
module ts_fifo
    import ts_pkg::*;
#(
    parameter int unsigned DEPTH = DepthDefault,
    parameter int unsigned CW    = CwDefault,
    parameter int unsigned LW    = level_width(DEPTH)
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [CW-1:0] wdata_i,
    output logic [CW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [CW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push_ok, pop_ok;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign level_o = level_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_ok && !pop_ok)      level_d = level_q + LW'(1);
        else if (!push_ok && pop_ok) level_d = level_q - LW'(1);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst && push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/timestamp_capture.sv
// Captures the system counter on each enabled rising edge of evt_in into a FIFO,
// with a sticky overflow flag for events dropped while the FIFO is full.
module timestamp_capture
    import ts_pkg::*;
#(
    parameter int unsigned DEPTH = DepthDefault,
    parameter int unsigned CW    = CwDefault,
    localparam int unsigned LW   = level_width(DEPTH)
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic [CW-1:0] count,
    input  logic          Cap_En,
    input  logic          evt_in,
    output logic [CW-1:0] ts_data,
    output logic          ts_valid,
    input  logic          ts_ready,
    output logic [LW-1:0] level,
    output logic          ovf,
    input  logic          ovf_clr
);

    logic evt_q;
    logic ovf_q, ovf_d;
    logic rise, capture, pop, push, full, empty, ovf_set;

    assign rise     = evt_in & ~evt_q;
    assign capture  = rise & Cap_En;
    assign pop      = ts_valid & ts_ready;
    assign push     = capture & (~full | pop);
    assign ovf_set  = capture & full & ~pop;
    assign ts_valid = ~empty;
    assign ovf      = ovf_q;

    // A new overflow wins over a simultaneous clear so no drop goes unreported.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_set)      ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
    end

    // evt_q resets high so a level held through reset release is not an edge.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            evt_q <= 1'b1;
            ovf_q <= 1'b0;
        end else begin
            evt_q <= evt_in;
            ovf_q <= ovf_d;
        end
    end

    ts_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW),
        .LW    (LW)
    ) u_fifo (
        .Clk     (Clk),
        .Rst     (Rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (count),
        .rdata_o (ts_data),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

endmodule

// File: tb/tb_timestamp_capture.sv
// Self-checking bench for timestamp_capture: scenario tasks with a queue scoreboard of
// expected timestamps in capture order.
module tb_timestamp_capture;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] count;
    logic        Cap_En;
    logic        evt_in;
    logic [31:0] ts_data;
    logic        ts_valid;
    logic        ts_ready;
    logic [3:0]  level;
    logic        ovf;
    logic        ovf_clr;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q [$];

    timestamp_capture #(
        .DEPTH (8),
        .CW    (32)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .count    (count),
        .Cap_En   (Cap_En),
        .evt_in   (evt_in),
        .ts_data  (ts_data),
        .ts_valid (ts_valid),
        .ts_ready (ts_ready),
        .level    (level),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    always #5 Clk = ~Clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse(input logic [31:0] c, input bit expect_write);
        evt_in = 1'b1;
        count  = c;
        if (expect_write) exp_q.push_back(c);
        cycle();
        evt_in = 1'b0;
        cycle();
    endtask

    task automatic drain(input string name);
        logic [31:0] exp;
        ts_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            checks++;
            if (ts_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s_valid: got %b expected 1", name, ts_valid);
            end else begin
                exp = exp_q.pop_front();
                if (ts_data !== exp) begin
                    errors++;
                    $display("FAIL %s_data: got %0h expected %0h", name, ts_data, exp);
                end
            end
            cycle();
        end
        checks++;
        if (exp_q.size() != 0 || ts_valid !== 1'b0 || level !== 4'd0) begin
            errors++;
            $display("FAIL %s_empty: valid=%b level=%0d left=%0d expected 0/0/0",
                     name, ts_valid, level, exp_q.size());
        end
        exp_q.delete();
        ts_ready = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1; Cap_En = 1'b1; evt_in = 1'b0; ts_ready = 1'b0; ovf_clr = 1'b0;
        count = 32'd0;
        cycle();
        cycle();
        Rst = 1'b0;
        checks++;
        if (ts_valid !== 1'b0 || level !== 4'd0 || ovf !== 1'b0 || ts_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b level=%0d ovf=%b data=%0h expected 0/0/0/0",
                     ts_valid, level, ovf, ts_data);
        end
        cycle();
    endtask

    task automatic test_single();
        logic [31:0] exp;
        ts_ready = 1'b1;
        evt_in   = 1'b1;
        count    = 32'd100;
        exp_q.push_back(32'd100);
        cycle();
        evt_in = 1'b0;
        count  = 32'd101;
        checks++;
        if (ts_valid !== 1'b1 || level !== 4'd1) begin
            errors++;
            $display("FAIL single_latency: got valid=%b level=%0d expected 1/1", ts_valid, level);
        end
        exp = exp_q.pop_front();
        checks++;
        if (ts_data !== exp) begin
            errors++;
            $display("FAIL single_data: got %0d expected %0d", ts_data, exp);
        end
        cycle();
        checks++;
        if (ts_valid !== 1'b0 || level !== 4'd0) begin
            errors++;
            $display("FAIL single_pop: got valid=%b level=%0d expected 0/0", ts_valid, level);
        end
        ts_ready = 1'b0;
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 8; i++) pulse(32'(10 * i), 1'b1);
        checks++;
        if (level !== 4'd8 || ovf !== 1'b0 || ts_data !== 32'd10) begin
            errors++;
            $display("FAIL ovf_fill: got level=%0d ovf=%b head=%0d expected 8/0/10",
                     level, ovf, ts_data);
        end
        pulse(32'd90, 1'b0);
        checks++;
        if (level !== 4'd8 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drop: got level=%0d ovf=%b expected 8/1", level, ovf);
        end
        drain("ovf_drain");
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b expected 1", ovf);
        end
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b expected 0", ovf);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        for (int i = 1; i <= 8; i++) pulse(32'(1000 + i), 1'b1);
        // Push and pop on the same edge while full.
        evt_in   = 1'b1;
        count    = 32'd5000;
        ts_ready = 1'b1;
        exp = exp_q.pop_front();
        checks++;
        if (ts_data !== exp) begin
            errors++;
            $display("FAIL b2b_head: got %0d expected %0d", ts_data, exp);
        end
        exp_q.push_back(32'd5000);
        cycle();
        evt_in   = 1'b0;
        ts_ready = 1'b0;
        checks++;
        if (level !== 4'd8 || ovf !== 1'b0 || ts_data !== exp_q[0]) begin
            errors++;
            $display("FAIL b2b_level: got level=%0d ovf=%b head=%0d expected 8/0/%0d",
                     level, ovf, ts_data, exp_q[0]);
        end
        cycle();
        // Overflow coinciding with a clear keeps the flag set.
        evt_in  = 1'b1;
        count   = 32'd6000;
        ovf_clr = 1'b1;
        cycle();
        evt_in  = 1'b0;
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b1 || level !== 4'd8) begin
            errors++;
            $display("FAIL ovf_set_priority: got ovf=%b level=%0d expected 1/8", ovf, level);
        end
        cycle();
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear2: got %b expected 0", ovf);
        end
        drain("b2b_drain");
    endtask

    task automatic test_wrap();
        pulse(32'hFFFF_FFFF, 1'b1);
        pulse(32'h0000_0001, 1'b1);
        checks++;
        if (level !== 4'd2) begin
            errors++;
            $display("FAIL wrap_level: got %0d expected 2", level);
        end
        drain("wrap_drain");
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 5; i++) pulse(32'(200 + i), 1'b1);
        checks++;
        if (level !== 4'd5) begin
            errors++;
            $display("FAIL rst_fill: got %0d expected 5", level);
        end
        Rst    = 1'b1;
        evt_in = 1'b1;
        count  = 32'd7777;
        cycle();
        Rst = 1'b0;
        exp_q.delete();
        checks++;
        if (level !== 4'd0 || ts_valid !== 1'b0 || ts_data !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid: got level=%0d valid=%b data=%0h expected 0/0/0",
                     level, ts_valid, ts_data);
        end
        cycle();
        cycle();
        checks++;
        if (level !== 4'd0) begin
            errors++;
            $display("FAIL rst_held_evt: got level=%0d expected 0", level);
        end
        evt_in = 1'b0;
        cycle();
        evt_in = 1'b1;
        count  = 32'd42;
        exp_q.push_back(32'd42);
        cycle();
        evt_in = 1'b0;
        checks++;
        if (level !== 4'd1) begin
            errors++;
            $display("FAIL rst_recapture: got level=%0d expected 1", level);
        end
        drain("rst_drain");
    endtask

    task automatic test_cap_en();
        Cap_En   = 1'b0;
        ts_ready = 1'b1;
        evt_in   = 1'b1;
        count    = 32'd300;
        cycle();
        checks++;
        if (level !== 4'd0 || ts_valid !== 1'b0) begin
            errors++;
            $display("FAIL capen_off: got level=%0d valid=%b expected 0/0", level, ts_valid);
        end
        Cap_En = 1'b1;
        cycle();
        cycle();
        checks++;
        if (level !== 4'd0) begin
            errors++;
            $display("FAIL capen_replay: got level=%0d expected 0", level);
        end
        evt_in = 1'b0;
        cycle();
        cycle();
        checks++;
        if (level !== 4'd0 || ts_valid !== 1'b0) begin
            errors++;
            $display("FAIL underflow: got level=%0d valid=%b expected 0/0", level, ts_valid);
        end
        ts_ready = 1'b0;
        pulse(32'd301, 1'b1);
        drain("capen_drain");
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_back_to_back();
        test_wrap();
        test_reset_midstream();
        test_cap_en();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timestamp_capture.md
TIMESTAMP_CAPTURE -- requirements
Module: timestamp_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, 2..64.
REQ-002 SHALL have parameter CW, default 32, timestamp width; matches system counter output width.
REQ-003 SHALL have port Clk  input  1  sole clock; all state updates on posedge Clk.
REQ-004 SHALL have port Rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port count  input  CW  free-running system counter value, same clock domain.
REQ-006 SHALL have port Cap_En  input  1  capture enable; when low, events are ignored and no FIFO writes occur.
REQ-007 SHALL have port evt_in  input  1  event strobe, already synchronous to Clk.
REQ-008 SHALL have port ts_data  output  CW  timestamp at FIFO head.
REQ-009 SHALL have port ts_valid  output  1  FIFO non-empty; ts_data is meaningful.
REQ-010 SHALL have port ts_ready  input  1  consumer accepts head when ts_valid and ts_ready are both high at posedge.
REQ-011 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 SHALL have port ovf  output  1  sticky overflow flag.
REQ-013 SHALL have port ovf_clr  input  1  clears ovf.

Function
REQ-014 SHALL register evt_in into evt_q each cycle; rising edge = evt_in & ~evt_q at a posedge.
REQ-015 SHALL, on a rising edge with Cap_En high, write the count value present at that same posedge into the FIFO tail.
REQ-016 SHALL make a written entry visible on ts_data/ts_valid one cycle after the capture edge; this is a fixed capture-to-valid latency of 1.
REQ-017 SHALL hold ts_data stable while ts_valid is high and ts_ready is low.
REQ-018 SHALL pop the head on a posedge where ts_valid and ts_ready are both high; the next entry, if any, SHALL appear in the following cycle with no bubble.
REQ-019 SHALL accept a push when level < DEPTH, or when level == DEPTH and a pop occurs in the same cycle (simultaneous push+pop at full).
REQ-020 SHALL leave level unchanged on a simultaneous push and pop.
REQ-021 SHALL, on a push attempt while full with no same-cycle pop, drop the event, leave the FIFO contents unchanged, and set ovf to 1.
REQ-022 SHALL ignore ts_ready when empty; level SHALL NOT underflow.
REQ-023 SHALL keep ovf at 1 until ovf_clr is high at a posedge.
REQ-024 SHALL give set priority when ovf_clr and a new overflow coincide, so ovf remains 1.
REQ-025 SHALL store count verbatim; wrap from 2^CW-1 to 0 needs no special handling, and the consumer computes modulo-2^CW deltas.
REQ-026 SHALL wrap pointers modulo DEPTH; level SHALL be tracked explicitly, not derived from pointers alone.
REQ-027 SHALL still update evt_q while Cap_En is low, so that an edge occurring while disabled is not replayed when Cap_En rises.

Reset
REQ-028 SHALL, on Rst high at a posedge, set read/write pointers=0, level=0, ts_valid=0, ovf=0, and evt_q=1; Rst SHALL take priority over all other inputs.
REQ-029 SHALL drive ts_data=0 after reset; FIFO storage need not be cleared.
REQ-030 SHALL discard a reset asserted mid-stream: the FIFO SHALL be empty the cycle after, and no capture SHALL occur in the reset cycle.
REQ-031 SHALL NOT treat evt_in held high through reset release as an event; capture requires a low-to-high transition after reset.

Structure
REQ-032 SHALL place CW default, DEPTH default, and the level width constant in shared package ts_pkg.
REQ-033 SHALL instantiate one sub-module, ts_fifo (sync FIFO, parameterised DEPTH/CW, push/pop/full/empty/level), with edge detect, overflow and gating in the top.

Verification
REQ-034 SHALL verify: count=100 at the evt_in rising edge, ts_ready=1 -> ts_valid high the next cycle with ts_data=100; popped the cycle after.
REQ-035 SHALL verify: 8 events with ts_ready=0 at count 10,20..80 -> level=8; a 9th event -> ovf=1, level=8; draining yields 10..80 in order.
REQ-036 SHALL verify: full FIFO with push and pop on the same posedge -> level stays 8, new timestamp at tail, no ovf.
REQ-037 SHALL verify: count=32'hFFFFFFFF then 32'h00000001 captured -> entries read back exactly as captured.
REQ-038 SHALL verify: Rst pulsed with level=5 and evt_in held high -> level=0, ts_valid=0, no capture until evt_in falls and rises again.
REQ-039 SHALL verify: Cap_En=0 during an edge -> no write; Cap_En rises while evt_in stays high -> still no write.
